// File: rtl/stopwatch_sequencer.sv
// Stopwatch run/pause/split sequencer: button conditioning, mode FSM,
// count prescaler, display freeze and lap time buffer.
module stopwatch_sequencer #(
  parameter int TICK_DIV     = 500000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LAP_DEPTH    = 8,
  localparam int AW          = $clog2(LAP_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_start,
  input  logic          btn_lap,
  input  logic [5:0]    cnt_min,
  input  logic [5:0]    cnt_sec,
  input  logic [6:0]    cnt_ms10,
  output logic          cnt_tick,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic [5:0]    disp_min,
  output logic [5:0]    disp_sec,
  output logic [6:0]    disp_ms10,
  output logic [1:0]    state_o,
  output logic [AW:0]   lap_cnt,
  output logic          lap_full,
  input  logic [AW-1:0] lap_rd_addr,
  output logic [18:0]   lap_rd_data
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_SPLIT = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_nxt;
  logic [1:0]           w_raw;
  logic [1:0]           r_s1;
  logic [1:0]           r_s2;
  logic [1:0]           r_lvl;
  logic [1:0]           r_lvl_d;
  logic [1:0][DW-1:0]   r_db;
  logic [1:0]           w_ev;
  logic                 w_ev_start;
  logic                 w_ev_lap;
  logic                 w_en;
  logic                 w_cap;
  logic                 w_clr;
  logic                 r_clr;
  logic                 w_tick;
  logic [PW-1:0]        r_pre;
  logic [AW:0]          r_lap_cnt;
  logic                 w_full;
  logic [18:0]          w_cnt;
  logic [18:0]          r_frz;
  logic [18:0]          r_mem [LAP_DEPTH];
  logic [18:0]          r_rd;

  assign w_raw = {btn_lap, btn_start};
  assign w_cnt = {cnt_min, cnt_sec, cnt_ms10};

  // Two-flop synchronizer for both raw buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after it has been stable for the full window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lvl   <= '0;
      r_lvl_d <= '0;
      r_db    <= '0;
    end else begin
      r_lvl_d <= r_lvl;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_lvl[i]) begin
          r_db[i] <= '0;
        end else if (r_db[i] == DW'(DEBOUNCE_CYC - 1)) begin
          r_db[i]  <= '0;
          r_lvl[i] <= r_s2[i];
        end else begin
          r_db[i] <= r_db[i] + DW'(1);
        end
      end
    end
  end

  // Start wins over lap when both fire together
  assign w_ev       = r_lvl & ~r_lvl_d;
  assign w_ev_start = w_ev[0];
  assign w_ev_lap   = w_ev[1] & ~w_ev[0];

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // FSM next-state decode
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_ev_start) w_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_ev_start)    w_nxt = S_PAUSE;
        else if (w_ev_lap) w_nxt = S_SPLIT;
      end
      S_SPLIT: begin
        if (w_ev_start)    w_nxt = S_PAUSE;
        else if (w_ev_lap) w_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (w_ev_start)    w_nxt = S_RUN;
        else if (w_ev_lap) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: core enable, lap capture strobe, clear request
  always_comb begin
    w_en  = 1'b0;
    w_cap = 1'b0;
    w_clr = 1'b0;
    unique case (1'b1)
      (r_state == S_RUN): begin
        w_en  = 1'b1;
        w_cap = w_ev_lap;
      end
      (r_state == S_SPLIT): w_en  = 1'b1;
      (r_state == S_PAUSE): w_clr = w_ev_lap;
      default: ;
    endcase
  end

  // Clear pulse lines up with the entry into IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_clr <= 1'b0;
    else      r_clr <= w_clr;
  end

  assign w_tick = w_en && (r_pre == PW'(TICK_DIV - 1));

  // Prescaler restarts a full period whenever counting resumes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_pre <= '0;
    else if (!w_en || r_clr || w_tick) r_pre <= '0;
    else                              r_pre <= r_pre + PW'(1);
  end

  assign w_full = (r_lap_cnt == (AW + 1)'(LAP_DEPTH));

  // Lap capture into buffer plus display freeze register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lap_cnt <= '0;
      r_frz     <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_clr) begin
      r_lap_cnt <= '0;
    end else if (w_cap) begin
      r_frz <= w_cnt;
      if (!w_full) begin
        r_mem[r_lap_cnt[AW-1:0]] <= w_cnt;
        r_lap_cnt <= r_lap_cnt + (AW + 1)'(1);
      end
    end
  end

  // Registered readout, zero beyond the stored laps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_rd <= '0;
    else if ({1'b0, lap_rd_addr} < r_lap_cnt)
      r_rd <= r_mem[lap_rd_addr];
    else
      r_rd <= '0;
  end

  assign cnt_tick    = w_tick;
  assign cnt_en      = w_en;
  assign cnt_clr     = r_clr;
  assign state_o     = r_state;
  assign lap_cnt     = r_lap_cnt;
  assign lap_full    = w_full;
  assign lap_rd_data = r_rd;
  assign {disp_min, disp_sec, disp_ms10} =
    (r_state == S_SPLIT) ? r_frz : w_cnt;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Bench for stopwatch_sequencer: vector table, corner sequences,
// and random button traffic against a transaction-level model.
module tb_stopwatch_sequencer;
  localparam int TD = 4;
  localparam int DC = 3;
  localparam int LD = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_start = 1'b0;
  logic          btn_lap = 1'b0;
  logic [5:0]    cnt_min = '0;
  logic [5:0]    cnt_sec = '0;
  logic [6:0]    cnt_ms10 = '0;
  logic          cnt_tick, cnt_en, cnt_clr;
  logic [5:0]    disp_min, disp_sec;
  logic [6:0]    disp_ms10;
  logic [1:0]    state_o;
  logic [AW:0]   lap_cnt;
  logic          lap_full;
  logic [AW-1:0] lap_rd_addr = '0;
  logic [18:0]   lap_rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int clr_cnt = 0;

  always #5 clk = ~clk;

  stopwatch_sequencer #(
    .TICK_DIV(TD), .DEBOUNCE_CYC(DC), .LAP_DEPTH(LD)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_lap(btn_lap),
    .cnt_min(cnt_min), .cnt_sec(cnt_sec), .cnt_ms10(cnt_ms10),
    .cnt_tick(cnt_tick), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .disp_min(disp_min), .disp_sec(disp_sec), .disp_ms10(disp_ms10),
    .state_o(state_o), .lap_cnt(lap_cnt), .lap_full(lap_full),
    .lap_rd_addr(lap_rd_addr), .lap_rd_data(lap_rd_data)
  );

  always @(negedge clk) if (cnt_clr === 1'b1) clr_cnt++;

  typedef struct {
    int          op;
    logic [18:0] v;
    logic [1:0]  addr;
    logic [1:0]  st;
    int          lc;
    logic [18:0] rd;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [18:0] V(int m, int s, int c);
    return {6'(m), 6'(s), 7'(c)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // op bit0 = start button, bit1 = lap button
  task automatic press(input int op, input logic [18:0] v);
    {cnt_min, cnt_sec, cnt_ms10} = v;
    btn_start = op[0];
    btn_lap   = op[1];
    step(DC + 3);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    step(DC + 5);
  endtask

  function automatic logic [18:0] disp_v();
    return {disp_min, disp_sec, disp_ms10};
  endfunction

  logic [18:0] L;
  int          m_st, m_lc;
  logic [18:0] m_laps [LD];
  logic [18:0] m_frz;

  initial begin
    L = V(59, 59, 99);
    tbl[0]  = '{2, V(9,9,9),    0, 0, 0, 19'd0};
    tbl[1]  = '{1, V(0,0,0),    0, 1, 0, 19'd0};
    tbl[2]  = '{2, V(1,2,3),    0, 3, 1, V(1,2,3)};
    tbl[3]  = '{2, V(4,4,4),    0, 1, 1, V(1,2,3)};
    tbl[4]  = '{2, V(5,6,7),    1, 3, 2, V(5,6,7)};
    tbl[5]  = '{2, V(8,8,8),    1, 1, 2, V(5,6,7)};
    tbl[6]  = '{2, V(10,20,30), 2, 3, 3, V(10,20,30)};
    tbl[7]  = '{2, V(1,1,1),    2, 1, 3, V(10,20,30)};
    tbl[8]  = '{2, V(11,22,33), 3, 3, 4, V(11,22,33)};
    tbl[9]  = '{2, V(2,2,2),    3, 1, 4, V(11,22,33)};
    tbl[10] = '{2, V(12,34,56), 3, 3, 4, V(11,22,33)};
    tbl[11] = '{2, V(3,3,3),    0, 1, 4, V(1,2,3)};
    tbl[12] = '{3, V(7,7,7),    1, 2, 4, V(5,6,7)};
    tbl[13] = '{1, V(0,0,0),    2, 1, 4, V(10,20,30)};
    tbl[14] = '{2, V(1,1,1),    3, 3, 4, V(11,22,33)};
    tbl[15] = '{1, V(0,0,0),    0, 2, 4, V(1,2,3)};
    tbl[16] = '{3, V(5,5,5),    0, 1, 4, V(1,2,3)};
    tbl[17] = '{1, V(0,0,0),    0, 2, 4, V(1,2,3)};
    tbl[18] = '{2, V(0,0,0),    0, 0, 0, 19'd0};

    // reset state
    step(3);
    chk("rst state", state_o, 0);
    chk("rst en", cnt_en, 0);
    chk("rst tick", cnt_tick, 0);
    chk("rst clr", cnt_clr, 0);
    chk("rst lap_cnt", lap_cnt, 0);
    chk("rst full", lap_full, 0);
    chk("rst rd", lap_rd_data, 0);
    chk("rst disp", disp_v(), 0);
    rst = 1'b1;
    step(2);

    // start latency and tick cadence
    btn_start = 1'b1;
    step(DC + 2);
    chk("start early", state_o, 0);
    step(1);
    chk("start state", state_o, 1);
    chk("start en", cnt_en, 1);
    for (int k = 0; k < 2 * TD; k++) begin
      chk($sformatf("tick%0d", k), cnt_tick, (k % TD) == TD - 1);
      step(1);
    end
    btn_start = 1'b0;
    step(DC + 5);

    // short glitch must be ignored
    btn_start = 1'b1;
    step(2);
    btn_start = 1'b0;
    step(DC + 8);
    chk("glitch state", state_o, 1);

    // pause then clear back to idle
    press(1, 19'd0);
    chk("pause state", state_o, 2);
    clr_cnt = 0;
    press(2, 19'd0);
    chk("clr state", state_o, 0);
    chk("clr pulses", clr_cnt, 1);
    chk("clr lap_cnt", lap_cnt, 0);

    // vector table
    foreach (tbl[i]) begin
      press(tbl[i].op, tbl[i].v);
      {cnt_min, cnt_sec, cnt_ms10} = L;
      lap_rd_addr = tbl[i].addr;
      step(1);
      chk($sformatf("vec%0d state", i), state_o, tbl[i].st);
      chk($sformatf("vec%0d lap_cnt", i), lap_cnt, tbl[i].lc);
      chk($sformatf("vec%0d full", i), lap_full, tbl[i].lc == LD);
      chk($sformatf("vec%0d rd", i), lap_rd_data, tbl[i].rd);
      chk($sformatf("vec%0d disp", i), disp_v(),
          (tbl[i].st == 3) ? tbl[i].v : L);
    end

    // asynchronous reset mid-run
    press(1, 19'd0);
    press(2, V(1,2,3));
    press(2, 19'd0);
    step(2);
    {cnt_min, cnt_sec, cnt_ms10} = '0;
    rst = 1'b0;
    #1;
    chk("arst state", state_o, 0);
    chk("arst en", cnt_en, 0);
    chk("arst tick", cnt_tick, 0);
    chk("arst lap_cnt", lap_cnt, 0);
    chk("arst rd", lap_rd_data, 0);
    chk("arst disp", disp_v(), 0);
    @(negedge clk);
    rst = 1'b1;
    btn_start = 1'b1;
    step(DC + 3);
    chk("arst restart", state_o, 1);
    for (int k = 0; k < TD; k++) begin
      chk($sformatf("arst tick%0d", k), cnt_tick, k == TD - 1);
      step(1);
    end
    btn_start = 1'b0;
    step(DC + 5);

    // random traffic against transaction model
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    m_st = 0;
    m_lc = 0;
    m_frz = '0;
    for (int n = 0; n < 40; n++) begin
      int r, op;
      logic [18:0] v, w;
      logic [1:0] a;
      r = $urandom_range(0, 9);
      op = (r < 3) ? 1 : (r < 9) ? 2 : 3;
      v = 19'($urandom);
      w = 19'($urandom);
      a = 2'($urandom_range(0, LD - 1));
      press(op, v);
      case (m_st)
        0: if (op[0]) m_st = 1;
        1: begin
          if (op[0]) m_st = 2;
          else begin
            m_st = 3;
            m_frz = v;
            if (m_lc < LD) begin
              m_laps[m_lc] = v;
              m_lc++;
            end
          end
        end
        3: m_st = op[0] ? 2 : 1;
        default: begin
          if (op[0]) m_st = 1;
          else begin
            m_st = 0;
            m_lc = 0;
          end
        end
      endcase
      {cnt_min, cnt_sec, cnt_ms10} = w;
      lap_rd_addr = a;
      step(1);
      chk($sformatf("rnd%0d state", n), state_o, m_st);
      chk($sformatf("rnd%0d lap_cnt", n), lap_cnt, m_lc);
      chk($sformatf("rnd%0d full", n), lap_full, m_lc == LD);
      chk($sformatf("rnd%0d en", n), cnt_en, m_st == 1 || m_st == 3);
      chk($sformatf("rnd%0d rd", n), lap_rd_data,
          (int'(a) < m_lc) ? m_laps[a] : 19'd0);
      chk($sformatf("rnd%0d disp", n), disp_v(),
          (m_st == 3) ? m_frz : w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
